cdb_prf_writeback: RTL and testbench

- Physical register file with per-register ready bits. It sits directly downstream of the 4-channel common data bus (channels 0-2 from the ALU/RS pipes, channel 3 from the LSQ).
- Each cycle it absorbs every valid CDB broadcast as a register write and sets that register's ready bit.
- It clears ready bits for registers newly allocated by rename.
- It serves 6 combinational source-operand reads (3-wide dispatch × 2 sources), with same-cycle CDB bypass.

---
 rtl/cdb_prf_writeback.sv | 102 ++++++++++
 tb/tb_cdb_prf_writeback.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_prf_writeback.sv
// Physical register file with per-register ready bits, fed by a 4-channel CDB.
// Absorbs CDB writes, clears ready on rename allocation, serves bypassed operand reads.
module cdb_prf_writeback #(
  parameter int unsigned DATA_WIDTH          = 32,
  parameter int unsigned PHYS_REG_ADDR_WIDTH = 6,
  parameter int unsigned NUM_PHYS_REGS       = 64,
  parameter int unsigned NUM_CDB             = 4,
  parameter int unsigned NUM_ALLOC           = 3,
  parameter int unsigned NUM_READ            = 6
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [NUM_CDB-1:0]                            cdb_valid,
  input  logic [NUM_CDB-1:0][2:0]                       cdb_tag,
  input  logic [NUM_CDB-1:0][PHYS_REG_ADDR_WIDTH-1:0]   cdb_dest_reg,
  input  logic [NUM_CDB-1:0][DATA_WIDTH-1:0]            cdb_data,
  input  logic [NUM_ALLOC-1:0]                          alloc_valid,
  input  logic [NUM_ALLOC-1:0][PHYS_REG_ADDR_WIDTH-1:0] alloc_preg,
  input  logic                                          flush,
  input  logic [NUM_READ-1:0][PHYS_REG_ADDR_WIDTH-1:0]  rd_addr,
  output logic [NUM_READ-1:0][DATA_WIDTH-1:0]           rd_data,
  output logic [NUM_READ-1:0]                           rd_ready,
  output logic [NUM_PHYS_REGS-1:0]                      ready_vec,
  output logic                                          multi_write_err
);

  logic [NUM_PHYS_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
  logic [NUM_PHYS_REGS-1:0]                 ready_q, ready_d;
  logic                                     err_q, err_d;

  // Tag is carried on the bus but has no role in the register file.
  logic unused_tag;
  assign unused_tag = ^cdb_tag;

  always_comb begin
    regs_d  = regs_q;
    ready_d = ready_q;
    err_d   = err_q;

    // Ascending channel order lets the highest index win a same-dest collision.
    for (int i = 0; i < NUM_CDB; i++) begin
      if (cdb_valid[i] && (cdb_dest_reg[i] != '0)) begin
        regs_d[cdb_dest_reg[i]]  = cdb_data[i];
        ready_d[cdb_dest_reg[i]] = 1'b1;
      end
    end

    for (int i = 0; i < NUM_CDB; i++) begin
      for (int j = i + 1; j < NUM_CDB; j++) begin
        if (cdb_valid[i] && cdb_valid[j] && (cdb_dest_reg[i] == cdb_dest_reg[j]) &&
            (cdb_dest_reg[i] != '0)) begin
          err_d = 1'b1;
        end
      end
    end

    // Allocation is applied after the CDB so a new producer leaves the bit cleared.
    if (flush) begin
      ready_d = '1;
    end else begin
      for (int k = 0; k < NUM_ALLOC; k++) begin
        if (alloc_valid[k] && (alloc_preg[k] != '0)) begin
          ready_d[alloc_preg[k]] = 1'b0;
        end
      end
    end

    regs_d[0]  = '0;
    ready_d[0] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q  <= '0;
      ready_q <= '1;
      err_q   <= 1'b0;
    end else begin
      regs_q  <= regs_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    rd_data  = '0;
    rd_ready = '0;
    for (int j = 0; j < NUM_READ; j++) begin
      rd_data[j]  = regs_q[rd_addr[j]];
      rd_ready[j] = ready_q[rd_addr[j]];
      for (int i = 0; i < NUM_CDB; i++) begin
        if (cdb_valid[i] && (cdb_dest_reg[i] == rd_addr[j]) && (rd_addr[j] != '0)) begin
          rd_data[j]  = cdb_data[i];
          rd_ready[j] = 1'b1;
        end
      end
    end
  end

  assign ready_vec       = ready_q;
  assign multi_write_err = err_q;

endmodule

// File: tb/tb_cdb_prf_writeback.sv
// Self-checking bench for cdb_prf_writeback: directed scenarios plus randomized traffic
// compared against an array-based reference model of the register file.
module tb_cdb_prf_writeback;

  logic             clk;
  logic             reset;
  logic [3:0]       cdb_valid;
  logic [3:0][2:0]  cdb_tag;
  logic [3:0][5:0]  cdb_dest_reg;
  logic [3:0][31:0] cdb_data;
  logic [2:0]       alloc_valid;
  logic [2:0][5:0]  alloc_preg;
  logic             flush;
  logic [5:0][5:0]  rd_addr;
  logic [5:0][31:0] rd_data;
  logic [5:0]       rd_ready;
  logic [63:0]      ready_vec;
  logic             multi_write_err;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [31:0] m_data  [64];
  logic        m_ready [64];
  logic        m_err;

  cdb_prf_writeback dut (
    .clk             (clk),
    .reset           (reset),
    .cdb_valid       (cdb_valid),
    .cdb_tag         (cdb_tag),
    .cdb_dest_reg    (cdb_dest_reg),
    .cdb_data        (cdb_data),
    .alloc_valid     (alloc_valid),
    .alloc_preg      (alloc_preg),
    .flush           (flush),
    .rd_addr         (rd_addr),
    .rd_data         (rd_data),
    .rd_ready        (rd_ready),
    .ready_vec       (ready_vec),
    .multi_write_err (multi_write_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    reset        = 1'b0;
    cdb_valid    = '0;
    cdb_tag      = '0;
    cdb_dest_reg = '0;
    cdb_data     = '0;
    alloc_valid  = '0;
    alloc_preg   = '0;
    flush        = 1'b0;
    rd_addr      = '0;
  endtask

  // Advance the model by one clock using the architectural rules, then clock the DUT.
  task automatic step();
    logic [31:0] nd [64];
    logic        nr [64];
    int          hits;
    int          win;
    for (int r = 0; r < 64; r++) begin
      nd[r] = m_data[r];
      nr[r] = m_ready[r];
    end
    if (reset) begin
      for (int r = 0; r < 64; r++) begin
        nd[r] = 32'h0;
        nr[r] = 1'b1;
      end
      m_err = 1'b0;
    end else begin
      for (int r = 1; r < 64; r++) begin
        hits = 0;
        win  = -1;
        for (int c = 0; c < 4; c++) begin
          if (cdb_valid[c] && int'(cdb_dest_reg[c]) == r) begin
            hits++;
            if (c > win) win = c;
          end
        end
        if (hits > 0) begin
          nd[r] = cdb_data[win];
          nr[r] = 1'b1;
        end
        if (hits > 1) m_err = 1'b1;
      end
      if (flush) begin
        for (int r = 0; r < 64; r++) nr[r] = 1'b1;
      end else begin
        for (int a = 0; a < 3; a++) begin
          if (alloc_valid[a] && alloc_preg[a] != 6'd0) nr[alloc_preg[a]] = 1'b0;
        end
      end
    end
    for (int r = 0; r < 64; r++) begin
      m_data[r]  = nd[r];
      m_ready[r] = nr[r];
    end
    @(posedge clk);
    #1;
  endtask

  function automatic void ref_read(input logic [5:0] addr, output logic [31:0] d,
                                   output logic rdy);
    d   = m_data[addr];
    rdy = m_ready[addr];
    if (addr != 6'd0) begin
      for (int c = 0; c < 4; c++) begin
        if (cdb_valid[c] && cdb_dest_reg[c] == addr) begin
          d   = cdb_data[c];
          rdy = 1'b1;
        end
      end
    end
    if (addr == 6'd0) begin
      d   = 32'h0;
      rdy = 1'b1;
    end
  endfunction

  function automatic logic [63:0] ref_ready_vec();
    logic [63:0] v;
    for (int r = 0; r < 64; r++) v[r] = m_ready[r];
    return v;
  endfunction

  task automatic test_reset();
    clear_inputs();
    reset        = 1'b1;
    cdb_valid    = 4'b0011;
    cdb_dest_reg = {6'd0, 6'd0, 6'd9, 6'd5};
    cdb_data     = {32'h0, 32'h0, 32'h1234, 32'h5678};
    alloc_valid  = 3'b001;
    alloc_preg   = {6'd0, 6'd0, 6'd5};
    step();
    step();
    clear_inputs();
    rd_addr[0] = 6'd5;
    rd_addr[1] = 6'd0;
    #1;
    n_checks++;
    if (rd_data[0] !== 32'h0 || rd_ready[0] !== 1'b1)
      $display("FAIL reset_rd5: got %h/%b expected 00000000/1", rd_data[0], rd_ready[0]);
    else n_pass++;
    n_checks++;
    if (rd_data[1] !== 32'h0 || rd_ready[1] !== 1'b1)
      $display("FAIL reset_rd0: got %h/%b expected 00000000/1", rd_data[1], rd_ready[1]);
    else n_pass++;
    n_checks++;
    if (ready_vec !== {64{1'b1}})
      $display("FAIL reset_ready_vec: got %h expected all ones", ready_vec);
    else n_pass++;
    n_checks++;
    if (multi_write_err !== 1'b0)
      $display("FAIL reset_err: got %b expected 0", multi_write_err);
    else n_pass++;
  endtask

  task automatic test_alloc_bypass();
    clear_inputs();
    alloc_valid[0] = 1'b1;
    alloc_preg[0]  = 6'd12;
    step();
    clear_inputs();
    rd_addr[0] = 6'd12;
    #1;
    n_checks++;
    if (rd_ready[0] !== 1'b0 || ready_vec[12] !== 1'b0)
      $display("FAIL alloc_clear: got rdy=%b vec=%b expected 0/0", rd_ready[0], ready_vec[12]);
    else n_pass++;
    cdb_valid[1]    = 1'b1;
    cdb_dest_reg[1] = 6'd12;
    cdb_data[1]     = 32'hDEADBEEF;
    #1;
    n_checks++;
    if (rd_data[0] !== 32'hDEADBEEF || rd_ready[0] !== 1'b1 || ready_vec[12] !== 1'b0)
      $display("FAIL bypass: got %h/%b vec=%b expected deadbeef/1 vec=0", rd_data[0],
               rd_ready[0], ready_vec[12]);
    else n_pass++;
    step();
    clear_inputs();
    rd_addr[0] = 6'd12;
    #1;
    n_checks++;
    if (rd_data[0] !== 32'hDEADBEEF || rd_ready[0] !== 1'b1 || ready_vec[12] !== 1'b1)
      $display("FAIL written: got %h/%b vec=%b expected deadbeef/1 vec=1", rd_data[0],
               rd_ready[0], ready_vec[12]);
    else n_pass++;
  endtask

  task automatic test_alloc_cdb_same();
    clear_inputs();
    alloc_valid[1]  = 1'b1;
    alloc_preg[1]   = 6'd20;
    cdb_valid[3]    = 1'b1;
    cdb_dest_reg[3] = 6'd20;
    cdb_data[3]     = 32'h55;
    rd_addr[2]      = 6'd20;
    #1;
    n_checks++;
    if (rd_data[2] !== 32'h55 || rd_ready[2] !== 1'b1)
      $display("FAIL alloc_cdb_bypass: got %h/%b expected 00000055/1", rd_data[2], rd_ready[2]);
    else n_pass++;
    step();
    clear_inputs();
    rd_addr[2] = 6'd20;
    #1;
    n_checks++;
    if (rd_data[2] !== 32'h55 || rd_ready[2] !== 1'b0 || ready_vec[20] !== 1'b0)
      $display("FAIL alloc_cdb_same: got %h/%b vec=%b expected 00000055/0 vec=0", rd_data[2],
               rd_ready[2], ready_vec[20]);
    else n_pass++;
  endtask

  task automatic test_collision();
    clear_inputs();
    cdb_valid       = 4'b0101;
    cdb_dest_reg[0] = 6'd7;
    cdb_data[0]     = 32'h11;
    cdb_dest_reg[2] = 6'd7;
    cdb_data[2]     = 32'h22;
    rd_addr[3]      = 6'd7;
    #1;
    n_checks++;
    if (rd_data[3] !== 32'h22 || rd_ready[3] !== 1'b1 || multi_write_err !== 1'b0)
      $display("FAIL collide_bypass: got %h/%b err=%b expected 00000022/1 err=0", rd_data[3],
               rd_ready[3], multi_write_err);
    else n_pass++;
    step();
    clear_inputs();
    rd_addr[3] = 6'd7;
    #1;
    n_checks++;
    if (rd_data[3] !== 32'h22 || multi_write_err !== 1'b1)
      $display("FAIL collide_store: got %h err=%b expected 00000022 err=1", rd_data[3],
               multi_write_err);
    else n_pass++;
    for (int k = 0; k < 3; k++) step();
    n_checks++;
    if (multi_write_err !== 1'b1)
      $display("FAIL err_sticky: got %b expected 1", multi_write_err);
    else n_pass++;
  endtask

  task automatic test_flush();
    clear_inputs();
    alloc_valid = 3'b111;
    alloc_preg  = {6'd32, 6'd31, 6'd30};
    step();
    clear_inputs();
    #1;
    n_checks++;
    if (ready_vec[32:30] !== 3'b000)
      $display("FAIL alloc3: got %b expected 000", ready_vec[32:30]);
    else n_pass++;
    flush          = 1'b1;
    alloc_valid[0] = 1'b1;
    alloc_preg[0]  = 6'd33;
    step();
    clear_inputs();
    #1;
    n_checks++;
    if (ready_vec[33:30] !== 4'b1111)
      $display("FAIL flush: got %b expected 1111", ready_vec[33:30]);
    else n_pass++;
  endtask

  task automatic test_preg0();
    clear_inputs();
    cdb_valid[1]    = 1'b1;
    cdb_dest_reg[1] = 6'd0;
    cdb_data[1]     = 32'hFFFF;
    alloc_valid[0]  = 1'b1;
    alloc_preg[0]   = 6'd0;
    #1;
    n_checks++;
    if (rd_data[0] !== 32'h0 || rd_ready[0] !== 1'b1)
      $display("FAIL preg0_same: got %h/%b expected 00000000/1", rd_data[0], rd_ready[0]);
    else n_pass++;
    step();
    clear_inputs();
    #1;
    n_checks++;
    if (rd_data[5] !== 32'h0 || rd_ready[5] !== 1'b1 || ready_vec[0] !== 1'b1)
      $display("FAIL preg0_after: got %h/%b vec=%b expected 00000000/1 vec=1", rd_data[5],
               rd_ready[5], ready_vec[0]);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] ed;
    logic        er;
    for (int cyc = 0; cyc < 400; cyc++) begin
      clear_inputs();
      reset = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 15) == 0);
      for (int c = 0; c < 4; c++) begin
        cdb_valid[c]    = $urandom_range(0, 1);
        cdb_tag[c]      = 3'($urandom);
        cdb_dest_reg[c] = 6'($urandom_range(0, 15));
        cdb_data[c]     = $urandom;
      end
      for (int a = 0; a < 3; a++) begin
        alloc_valid[a] = $urandom_range(0, 1);
        alloc_preg[a]  = 6'($urandom_range(0, 15));
      end
      for (int j = 0; j < 6; j++) begin
        rd_addr[j] = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'($urandom_range(0, 15));
      end
      #1;
      for (int j = 0; j < 6; j++) begin
        ref_read(rd_addr[j], ed, er);
        n_checks++;
        if (rd_data[j] !== ed || rd_ready[j] !== er)
          $display("FAIL rand_read cyc%0d port%0d addr%0d: got %h/%b expected %h/%b", cyc, j,
                   rd_addr[j], rd_data[j], rd_ready[j], ed, er);
        else n_pass++;
      end
      n_checks++;
      if (ready_vec !== ref_ready_vec() || multi_write_err !== m_err)
        $display("FAIL rand_state cyc%0d: got vec=%h err=%b expected vec=%h err=%b", cyc,
                 ready_vec, multi_write_err, ref_ready_vec(), m_err);
      else n_pass++;
      step();
    end
  endtask

  initial begin
    for (int r = 0; r < 64; r++) begin
      m_data[r]  = 32'h0;
      m_ready[r] = 1'b1;
    end
    m_err = 1'b0;
    clear_inputs();
    @(posedge clk);
    #1;
    test_reset();
    test_alloc_bypass();
    test_alloc_cdb_same();
    test_collision();
    test_flush();
    test_preg0();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
